// File: rtl/dual_pwm_driver.sv
// dual_pwm_driver
// Purpose : two-channel PWM generator for the X/Y actuators. Duty commands
//           (6-bit, 1/64 units) are latched only at PWM period boundaries so
//           the outputs never glitch; an optional slew limiter moves each
//           channel by at most one step per period.
// Latency : PWM outputs lag the phase counter and applied duty by one
//           registered cycle; new duty values appear together with
//           o_period_strobe on the cycle after the boundary.
// Backpressure: none; free-running generator gated only by i_enable.
//
// Ports:
//   i_sysclk         system clock, rising edge
//   i_reset          asynchronous, active-high reset; clears all state
//   i_enable         run control; low holds and clears the counters
//   i_slew_en        1 = limit duty change to +/-1 per period (sampled at boundary)
//   i_dc_x, i_dc_y   commanded duty per channel
//   o_pwm_x, o_pwm_y registered PWM outputs
//   o_cur_x, o_cur_y duty currently applied
//   o_period_strobe  one-cycle pulse at each period start

module dual_pwm_driver #(
    parameter int PRESCALE = 16
) (
    input  logic       i_sysclk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic       i_slew_en,
    input  logic [5:0] i_dc_x,
    input  logic [5:0] i_dc_y,
    output logic       o_pwm_x,
    output logic       o_pwm_y,
    output logic [5:0] o_cur_x,
    output logic [5:0] o_cur_y,
    output logic       o_period_strobe
);

    // A prescaler of 1 still needs a 1-bit register; it just never leaves 0.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_presc;
    logic [5:0]    r_phase;
    logic [5:0]    r_cur_x;
    logic [5:0]    r_cur_y;
    logic          r_pwm_x;
    logic          r_pwm_y;
    logic          r_strobe;

    logic          w_tick;
    logic          w_boundary;
    logic [5:0]    w_next_x;
    logic [5:0]    w_next_y;

    // Next applied duty at a boundary: either jump straight to the command,
    // or step one unit toward it and hold once it is reached.
    function automatic logic [5:0] next_duty(
        input logic [5:0] cur,
        input logic [5:0] dc,
        input logic       slew
    );
        logic [5:0] res;
        res = dc;
        if (slew) begin
            if (cur < dc) begin
                res = cur + 6'd1;
            end else if (cur > dc) begin
                res = cur - 6'd1;
            end else begin
                res = cur;
            end
        end
        return res;
    endfunction

    assign w_tick     = (r_presc == PRESC_LAST);
    assign w_boundary = w_tick && (r_phase == 6'd63);
    assign w_next_x   = next_duty(r_cur_x, i_dc_x, i_slew_en);
    assign w_next_y   = next_duty(r_cur_y, i_dc_y, i_slew_en);

    always_ff @(posedge i_sysclk or posedge i_reset) begin
        if (i_reset) begin
            r_presc  <= '0;
            r_phase  <= 6'd0;
            r_cur_x  <= 6'd0;
            r_cur_y  <= 6'd0;
            r_pwm_x  <= 1'b0;
            r_pwm_y  <= 1'b0;
            r_strobe <= 1'b0;
        end else if (!i_enable) begin
            // Idle: counters parked at the start of a period so that a later
            // enable begins a full period; duty tracks the command directly.
            r_presc  <= '0;
            r_phase  <= 6'd0;
            r_cur_x  <= i_dc_x;
            r_cur_y  <= i_dc_y;
            r_pwm_x  <= 1'b0;
            r_pwm_y  <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            if (w_tick) begin
                r_presc <= '0;
                r_phase <= r_phase + 6'd1;   // wraps 63 -> 0 naturally
            end else begin
                r_presc <= r_presc + PW'(1);
            end

            r_strobe <= w_boundary;

            if (w_boundary) begin
                r_cur_x <= w_next_x;
                r_cur_y <= w_next_y;
            end

            // Compare uses the registered phase/duty, so the output is one
            // cycle behind them; phase 63 never compares true, which caps
            // duty at 63/64.
            r_pwm_x <= (r_phase < r_cur_x);
            r_pwm_y <= (r_phase < r_cur_y);
        end
    end

    assign o_pwm_x         = r_pwm_x;
    assign o_pwm_y         = r_pwm_y;
    assign o_cur_x         = r_cur_x;
    assign o_cur_y         = r_cur_y;
    assign o_period_strobe = r_strobe;

endmodule

// File: tb/tb_dual_pwm_driver.sv
// Self-checking bench for dual_pwm_driver with PRESCALE = 2 (128-cycle period).
// Duty vectors are applied from a table; each vector's expectations are queued
// when it is driven and checked when the boundary that applies it arrives.
module tb_dual_pwm_driver;

    localparam int PRESCALE = 2;
    localparam int PERIOD   = 64 * PRESCALE;
    localparam int NVEC     = 10;

    logic       clk;
    logic       rst;
    logic       en;
    logic       slew;
    logic [5:0] dcx;
    logic [5:0] dcy;
    logic       pwm_x;
    logic       pwm_y;
    logic [5:0] cur_x;
    logic [5:0] cur_y;
    logic       strobe;

    dual_pwm_driver #(.PRESCALE(PRESCALE)) dut (
        .i_sysclk        (clk),
        .i_reset         (rst),
        .i_enable        (en),
        .i_slew_en       (slew),
        .i_dc_x          (dcx),
        .i_dc_y          (dcy),
        .o_pwm_x         (pwm_x),
        .o_pwm_y         (pwm_y),
        .o_cur_x         (cur_x),
        .o_cur_y         (cur_y),
        .o_period_strobe (strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       slew;
        logic [5:0] dx;
        logic [5:0] dy;
        logic [5:0] cx;   // applied duty expected after the next boundary
        logic [5:0] cy;
        int         hx;   // expected high cycles in the following period
        int         hy;
    } vec_t;

    vec_t vecs [NVEC];
    vec_t sb [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Counts negedges until a strobe is seen; -1 on timeout.
    task automatic wait_strobe(output int n);
        n = -1;
        for (int k = 1; k <= 3 * PERIOD; k++) begin
            @(negedge clk);
            if (strobe === 1'b1) begin
                n = k;
                return;
            end
        end
    endtask

    task automatic drive_vec(input vec_t v);
        slew = v.slew;
        dcx  = v.dx;
        dcy  = v.dy;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        vec_t e;
        int   hx, hy, shape, early, got_end;
        logic ex, ey;

        //            slew  dx     dy     cx     cy     hx   hy
        vecs[0] = '{1'b0, 6'd16, 6'd40, 6'd16, 6'd40,  32,  80};
        vecs[1] = '{1'b0, 6'd0,  6'd8,  6'd0,  6'd8,    0,  16};
        vecs[2] = '{1'b0, 6'd63, 6'd63, 6'd63, 6'd63, 126, 126};
        vecs[3] = '{1'b0, 6'd0,  6'd40, 6'd0,  6'd40,   0,  80};
        vecs[4] = '{1'b1, 6'd3,  6'd40, 6'd1,  6'd40,   2,  80};
        vecs[5] = '{1'b1, 6'd3,  6'd40, 6'd2,  6'd40,   4,  80};
        vecs[6] = '{1'b1, 6'd3,  6'd40, 6'd3,  6'd40,   6,  80};
        vecs[7] = '{1'b1, 6'd3,  6'd40, 6'd3,  6'd40,   6,  80};
        vecs[8] = '{1'b1, 6'd1,  6'd40, 6'd2,  6'd40,   4,  80};
        vecs[9] = '{1'b1, 6'd1,  6'd40, 6'd1,  6'd40,   2,  80};

        rst  = 1'b1;
        en   = 1'b0;
        slew = 1'b0;
        dcx  = 6'd0;
        dcy  = 6'd0;
        repeat (2) @(negedge clk);
        check("reset_pwm_x",  pwm_x,  0);
        check("reset_pwm_y",  pwm_y,  0);
        check("reset_cur_x",  cur_x,  0);
        check("reset_cur_y",  cur_y,  0);
        check("reset_strobe", strobe, 0);

        drive_vec(vecs[0]);
        sb.push_back(vecs[0]);
        en  = 1'b1;
        rst = 1'b0;
        wait_strobe(n);
        check("first_strobe_delay", n, PERIOD);

        // Table: each iteration starts on a strobe cycle and covers one period.
        // The next vector is driven mid-period (around phase 20) and must not
        // disturb the period in progress.
        for (int i = 0; i < NVEC; i++) begin
            if (sb.size() == 0) begin
                check("scoreboard_empty", 1, 0);
                break;
            end
            e = sb.pop_front();
            check($sformatf("v%0d_cur_x", i), cur_x, e.cx);
            check($sformatf("v%0d_cur_y", i), cur_y, e.cy);
            hx = 0; hy = 0; shape = 0; early = 0; got_end = 0;
            for (int j = 1; j <= PERIOD; j++) begin
                @(negedge clk);
                ex = (((j - 1) / PRESCALE) < int'(e.cx));
                ey = (((j - 1) / PRESCALE) < int'(e.cy));
                if (pwm_x === 1'b1) hx++;
                if (pwm_y === 1'b1) hy++;
                if (pwm_x !== ex || pwm_y !== ey) shape++;
                if (j < PERIOD && strobe !== 1'b0) early++;
                if (j == PERIOD) got_end = (strobe === 1'b1) ? 1 : 0;
                if (j == 40 && i + 1 < NVEC) begin
                    drive_vec(vecs[i + 1]);
                    sb.push_back(vecs[i + 1]);
                end
            end
            check($sformatf("v%0d_high_x", i), hx, e.hx);
            check($sformatf("v%0d_high_y", i), hy, e.hy);
            check($sformatf("v%0d_shape_errs", i), shape, 0);
            check($sformatf("v%0d_early_strobes", i), early, 0);
            check($sformatf("v%0d_strobe_spacing", i), got_end, 1);
        end

        // Asynchronous reset in the middle of a high PWM stretch.
        slew = 1'b0;
        dcx  = 6'd16;
        dcy  = 6'd40;
        wait_strobe(n);
        check("pre_reset_cur_x", cur_x, 16);
        repeat (10) @(negedge clk);
        check("pre_reset_pwm_x", pwm_x, 1);
        rst = 1'b1;
        #1;
        check("async_reset_pwm_x",  pwm_x,  0);
        check("async_reset_pwm_y",  pwm_y,  0);
        check("async_reset_cur_x",  cur_x,  0);
        check("async_reset_cur_y",  cur_y,  0);
        check("async_reset_strobe", strobe, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_strobe(n);
        check("post_reset_strobe_delay", n, PERIOD);
        check("post_reset_cur_x", cur_x, 16);
        check("post_reset_cur_y", cur_y, 40);

        // Enable drop mid-period with slewing requested.
        slew = 1'b1;
        repeat (10) @(negedge clk);
        en  = 1'b0;
        dcx = 6'd50;
        @(negedge clk);
        check("disable_pwm_x",  pwm_x,  0);
        check("disable_pwm_y",  pwm_y,  0);
        check("disable_strobe", strobe, 0);
        check("disable_cur_x_follow", cur_x, 50);
        check("disable_cur_y_follow", cur_y, 40);
        dcx = 6'd5;
        @(negedge clk);
        check("disable_cur_x_no_slew", cur_x, 5);
        n = 0;
        for (int k = 0; k < 2 * PERIOD; k++) begin
            @(negedge clk);
            if (strobe !== 1'b0 || pwm_x !== 1'b0) n++;
        end
        check("disabled_activity", n, 0);
        en = 1'b1;
        wait_strobe(n);
        check("reenable_strobe_delay", n, PERIOD);
        check("reenable_cur_x", cur_x, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dual_pwm_driver.md
# dual_pwm_driver

Two-channel PWM generator that turns the 6-bit duty values played back by the trajectory recorder (DC_X / DC_Y) into the X and Y actuator drive waveforms. It latches new duty values only at PWM period boundaries, so outputs never glitch. An optional slew limiter moves each channel at most one step per period. Period_Strobe marks each period boundary for downstream pacing logic.

## Interface
- PRESCALE, 16: sysclk cycles per PWM tick; legal range ≥1.
- sysclk  in  1  system clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- Enable  in  1  run control; low stops and clears the counters.
- Slew_En  in  1  1 = limit duty change to ±1 per period.
- DC_X  in  6  commanded duty, X channel, in 1/64 units.
- DC_Y  in  6  commanded duty, Y channel, in 1/64 units.
- PWM_X  out  1  registered PWM output, X.
- PWM_Y  out  1  registered PWM output, Y.
- Cur_X  out  6  duty currently applied, X.
- Cur_Y  out  6  duty currently applied, Y.
- Period_Strobe  out  1  one-cycle pulse at each period start.

## Operation
- **Reset values:** all outputs are 0; the prescaler and the 6-bit Phase counter are also 0.
- **Prescaler:** counts 0..PRESCALE-1 and wraps. Tick = prescaler at PRESCALE-1. When PRESCALE = 1, tick is asserted every cycle.
- **Phase:** increments on each tick and wraps 63→0. Period = 64 ticks.
- **Boundary event (B):** B occurs when tick is asserted and Phase = 63. On the edge where B occurs:
  - Phase goes to 0.
  - Period_Strobe goes to 1 for exactly one cycle.
  - Cur_X and Cur_Y update as follows:
    - Slew_En = 0: Cur ← DC.
    - Slew_En = 1: if Cur < DC then Cur+1; if Cur > DC then Cur−1; if Cur = DC then hold.
  - Slew_En is sampled only at B.
- **Between boundaries:** DC_X and DC_Y are ignored. A mid-period change takes effect at the next B.
- **PWM outputs:** every cycle, PWM_n ← Enable & (Phase < Cur_n). The compare is unsigned, 6-bit.
  - Cur = 0 → output is always low.
  - Cur = 63 → output is high for 63 of 64 ticks. 100% duty is not reachable by design.
- **Enable = 0:**
  - Prescaler and Phase are held at 0.
  - PWM_X, PWM_Y and Period_Strobe go to 0 on the next edge.
  - Cur_n ← DC_n every cycle, with no slewing.
- **Enable rising:** counting starts from Phase 0. No strobe is issued for that first partial period. The first strobe follows the first B.
- **X and Y channels:** the channels are independent, but share the prescaler, Phase and strobe.

## Timing
- Period = 64 × PRESCALE sysclk cycles. Strobe spacing equals the period exactly while Enable = 1.
- The cycle after B shows all of the following together: Phase = 0, Period_Strobe = 1, new Cur values.
- PWM lags Phase/Cur by one registered cycle. The first PWM edge of a period appears one cycle after the strobe.
- High time per period = Cur × PRESCALE cycles, exact and jitter-free.
- Slew mode: reaching a target at distance d takes d periods.
- Reset mid-operation: outputs clear immediately (asynchronous). After Reset falls, behaviour restarts from Phase 0 the same as an Enable rise.

## Test plan
Benches use PRESCALE = 2 (period = 128 cycles).

- **Reset:** assert Reset mid-period with PWM_X high → PWM_X, PWM_Y, Cur_X, Cur_Y and Period_Strobe all 0 immediately, before any clock edge. Release → first strobe 128 cycles after Enable.
- **Basic duty:** Enable = 1, Slew_En = 0, DC_X = 16, DC_Y = 40 →
  - after the first strobe, Cur_X = 16 and Cur_Y = 40;
  - per period, PWM_X is high for 32 cycles and PWM_Y for 80;
  - strobes every 128 cycles.
- **Extremes:** DC_X = 0 → PWM_X never high. DC_X = 63 → PWM_X high 126 of 128 cycles, low for the final 2.
- **Slew limiting:** Slew_En = 1, Cur_X = 0, DC_X = 3 → Cur_X reads 1, 2, 3 on successive strobes, then holds at 3. Then DC_X = 1 → Cur_X reads 2, 1 on the next two strobes.
- **Mid-period change:** change DC_Y from 40 to 8 at Phase 20 → the current period still has 80 high cycles. The next period has 16 high cycles.
- **Enable drop:** deassert Enable mid-period →
  - PWM_X and PWM_Y go low on the next edge and no strobe occurs;
  - Cur follows DC each cycle, with no slewing even if Slew_En = 1;
  - on re-enable, the first strobe comes after 128 cycles.
